// File: rtl/tlc_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
//   Definitions shared by the traffic-light controller slice.
//   - deb_state_t : encoding of the vehicle-sensor debounce FSM
//   - DEB_CYCLES_DEF : default number of stable samples to accept a level change
//   - is_present() : debounced sensor level implied by a debounce state
// -----------------------------------------------------------------------------
package tlc_pkg;

    typedef enum logic [1:0] {
        ABSENT   = 2'd0,
        RISE_CHK = 2'd1,
        PRESENT  = 2'd2,
        FALL_CHK = 2'd3
    } deb_state_t;

    localparam int DEB_CYCLES_DEF = 4;

    // The debounced level only drops once a falling edge has been confirmed,
    // so FALL_CHK still reports the vehicle as present.
    function automatic logic is_present(input deb_state_t st);
        return (st == PRESENT) || (st == FALL_CHK);
    endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Two-flop synchronizer for a single asynchronous input.
//   Ports:
//     clk   in  destination clock, rising edge
//     reset in  asynchronous, active-low reset (both flops clear to 0)
//     d     in  asynchronous input
//     q     out synchronized output, 2 clk latency
// -----------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/vehicle_detect.sv
// -----------------------------------------------------------------------------
// vehicle_detect
//   Conditions the raw farm-road loop sensor into the detect request for the
//   traffic-light controller: synchronize, debounce, latch a request per
//   debounced arrival, and count waiting vehicles until farm green.
//
//   Optional feature macro: STUCK_DETECT_EN
//     defined   -> stuck-high monitor; fault is sticky and forces detect=1
//     undefined -> no monitor; fault tied to 0
//
//   Parameters:
//     DEB_CYCLES   stable synchronized samples to accept a level change (>=1)
//     CNT_W        width of the waiting-vehicle counter
//     STUCK_CYCLES continuous presence cycles before a stuck fault
//   Ports:
//     clk        in  system clock, rising edge
//     reset      in  asynchronous, active-low reset
//     sensor_raw in  raw loop sensor, asynchronous, may bounce
//     fg         in  farm green from the controller
//     detect     out registered vehicle-waiting request
//     present    out debounced sensor level
//     car_cnt    out vehicles arrived since last farm green, saturating
//     fault      out sensor stuck high
// -----------------------------------------------------------------------------
module vehicle_detect
    import tlc_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int CNT_W        = 4,
    parameter int STUCK_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_raw,
    input  logic             fg,
    output logic             detect,
    output logic             present,
    output logic [CNT_W-1:0] car_cnt,
    output logic             fault
);

    localparam int                DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic             s;
    deb_state_t       state_reg, state_next;
    logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
    logic             arrive;
    logic             fg_d_reg;
    logic             fg_rise, fg_fall;
    logic             detect_reg, detect_next;
    logic [CNT_W-1:0] car_cnt_reg, car_cnt_next;
    logic             fault_next;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sensor_raw),
        .q     (s)
    );

    // ---------------- debounce FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ABSENT;
            deb_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            deb_cnt_reg <= deb_cnt_next;
        end
    end

    // The check states compare with >= so DEB_CYCLES==1 still leaves them
    // after a single cycle even though entry loads the counter with 1.
    always_comb begin
        state_next   = state_reg;
        deb_cnt_next = deb_cnt_reg;
        arrive       = 1'b0;
        case (state_reg)
            ABSENT: begin
                if (s) begin
                    state_next   = RISE_CHK;
                    deb_cnt_next = DEB_W'(1);
                end
            end
            RISE_CHK: begin
                if (!s) begin
                    state_next   = ABSENT;
                    deb_cnt_next = '0;
                end else if (deb_cnt_reg >= DEB_LAST) begin
                    state_next   = PRESENT;
                    deb_cnt_next = '0;
                    arrive       = 1'b1;
                end else begin
                    deb_cnt_next = deb_cnt_reg + DEB_W'(1);
                end
            end
            PRESENT: begin
                if (!s) begin
                    state_next   = FALL_CHK;
                    deb_cnt_next = DEB_W'(1);
                end
            end
            FALL_CHK: begin
                if (s) begin
                    state_next   = PRESENT;
                    deb_cnt_next = '0;
                end else if (deb_cnt_reg >= DEB_LAST) begin
                    state_next   = ABSENT;
                    deb_cnt_next = '0;
                end else begin
                    deb_cnt_next = deb_cnt_reg + DEB_W'(1);
                end
            end
            default: begin
                state_next   = ABSENT;
                deb_cnt_next = '0;
            end
        endcase
    end

    assign present = is_present(state_reg);

    // ---------------- request latch and vehicle counter ----------------
    assign fg_rise = fg & ~fg_d_reg;
    assign fg_fall = ~fg & fg_d_reg;

    always_comb begin
        detect_next = detect_reg;
        if (fg) begin
            // Any arrival while green is being served counts as served.
            detect_next = 1'b0;
        end else if (arrive) begin
            detect_next = 1'b1;
        end else if (fg_fall && present) begin
            // Car still on the loop when green ended: ask again.
            detect_next = 1'b1;
        end
        if (fault_next) begin
            detect_next = 1'b1;
        end
    end

    always_comb begin
        car_cnt_next = car_cnt_reg;
        if (fg_rise) begin
            car_cnt_next = '0;
        end else if (arrive && !fg && (car_cnt_reg != CNT_MAX)) begin
            car_cnt_next = car_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fg_d_reg    <= 1'b0;
            detect_reg  <= 1'b0;
            car_cnt_reg <= '0;
        end else begin
            fg_d_reg    <= fg;
            detect_reg  <= detect_next;
            car_cnt_reg <= car_cnt_next;
        end
    end

    assign detect  = detect_reg;
    assign car_cnt = car_cnt_reg;

    // ---------------- optional stuck-high monitor ----------------
`ifdef STUCK_DETECT_EN
    localparam int                 STUCK_W   = $clog2(STUCK_CYCLES + 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

    logic [STUCK_W-1:0] stuck_cnt_reg, stuck_cnt_next;
    logic               fault_reg;

    // Counter saturates at the threshold so it can never wrap back below it.
    always_comb begin
        stuck_cnt_next = stuck_cnt_reg;
        if (!present) begin
            stuck_cnt_next = '0;
        end else if (stuck_cnt_reg != STUCK_MAX) begin
            stuck_cnt_next = stuck_cnt_reg + STUCK_W'(1);
        end
        fault_next = fault_reg | (stuck_cnt_next == STUCK_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stuck_cnt_reg <= '0;
            fault_reg     <= 1'b0;
        end else begin
            stuck_cnt_reg <= stuck_cnt_next;
            fault_reg     <= fault_next;
        end
    end

    assign fault = fault_reg;
`else
    // The stuck threshold has no effect without the monitor.
    logic [31:0] unused_stuck_cfg;
    assign unused_stuck_cfg = 32'(STUCK_CYCLES);
    assign fault_next       = 1'b0;
    assign fault            = 1'b0;
`endif

endmodule

// File: tb/tb_vehicle_detect.sv
module tb_vehicle_detect;

    logic       clk;
    logic       reset;
    logic       sensor_raw;
    logic       fg;
    logic       detect;
    logic       present;
    logic [3:0] car_cnt;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       sensor;
        logic       fg;
        int         cycles;
        logic       exp_detect;
        logic       exp_present;
        logic [3:0] exp_cnt;
        logic       exp_fault;
        string      name;
    } vec_t;

    vec_t table_q[$];
    vec_t exp_q[$];

    vehicle_detect #(
        .DEB_CYCLES   (4),
        .CNT_W        (4),
        .STUCK_CYCLES (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sensor_raw (sensor_raw),
        .fg         (fg),
        .detect     (detect),
        .present    (present),
        .car_cnt    (car_cnt),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic sen, input logic f, input int n,
                                input logic d, input logic p, input logic [3:0] c,
                                input logic flt, input string nm);
        vec_t v;
        v.sensor = sen; v.fg = f; v.cycles = n;
        v.exp_detect = d; v.exp_present = p; v.exp_cnt = c;
        v.exp_fault = flt; v.name = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Pops the oldest expectation and compares it with the outputs now.
    task automatic check_pop();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=0 want=1");
        end else begin
            e = exp_q.pop_front();
            $display("vec %-18s sensor=%0d fg=%0d cyc=%0d -> detect=%0d present=%0d car_cnt=%0d fault=%0d",
                     e.name, e.sensor, e.fg, e.cycles, detect, present, car_cnt, fault);
            chk({e.name, ".detect"},  8'(detect),  8'(e.exp_detect));
            chk({e.name, ".present"}, 8'(present), 8'(e.exp_present));
            chk({e.name, ".car_cnt"}, 8'(car_cnt), 8'(e.exp_cnt));
            chk({e.name, ".fault"},   8'(fault),   8'(e.exp_fault));
        end
    endtask

    // Called on a negedge: drive, record expectation, advance, compare.
    task automatic apply_vec(input vec_t v);
        sensor_raw = v.sensor;
        fg         = v.fg;
        exp_q.push_back(v);
        repeat (v.cycles) @(negedge clk);
        check_pop();
    endtask

    // Async reset between clock edges; outputs must clear before any edge.
    task automatic async_reset_check(input string nm);
        #3 reset = 1'b0;
        #1;
        $display("rst %-18s detect=%0d present=%0d car_cnt=%0d fault=%0d",
                 nm, detect, present, car_cnt, fault);
        chk({nm, ".detect"},  8'(detect),  8'd0);
        chk({nm, ".present"}, 8'(present), 8'd0);
        chk({nm, ".car_cnt"}, 8'(car_cnt), 8'd0);
        chk({nm, ".fault"},   8'(fault),   8'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] sat;

        // Basic sequence: rise latency, fall latency, fg clear, glitch.
        table_q.push_back(mk(1, 0, 5, 0, 0, 4'd0,  0, "rise_wait"));
        table_q.push_back(mk(1, 0, 1, 1, 1, 4'd1,  0, "rise_edge"));
        table_q.push_back(mk(0, 0, 5, 1, 1, 4'd1,  0, "fall_wait"));
        table_q.push_back(mk(0, 0, 1, 1, 0, 4'd1,  0, "fall_edge"));
        table_q.push_back(mk(0, 1, 1, 0, 0, 4'd0,  0, "fg_clear"));
        table_q.push_back(mk(0, 0, 1, 0, 0, 4'd0,  0, "fg_off"));
        table_q.push_back(mk(1, 0, 3, 0, 0, 4'd0,  0, "glitch_hi"));
        table_q.push_back(mk(0, 0, 6, 0, 0, 4'd0,  0, "glitch_lo"));
        // Twenty clean pulses: counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            sat = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            table_q.push_back(mk(1, 0, 8, 1, 1, sat, 0, "pulse_hi"));
            table_q.push_back(mk(0, 0, 8, 1, 0, sat, 0, "pulse_lo"));
        end
        // Green serves the request; arrival during green stays unrequested;
        // car still present when green ends re-requests.
        table_q.push_back(mk(0, 1, 1, 0, 0, 4'd0,  0, "fg_clr_sat"));
        table_q.push_back(mk(1, 1, 8, 0, 1, 4'd0,  0, "arrive_in_fg"));
        table_q.push_back(mk(1, 0, 1, 1, 1, 4'd0,  0, "fg_fall_present"));
        table_q.push_back(mk(0, 0, 8, 1, 0, 4'd0,  0, "leave"));
        // Arrival on the exact cycle fg rises: served, not counted.
        table_q.push_back(mk(1, 0, 5, 1, 0, 4'd0,  0, "pre_arrive"));
        table_q.push_back(mk(1, 1, 1, 0, 1, 4'd0,  0, "arrive_on_fg_rise"));
        table_q.push_back(mk(0, 1, 8, 0, 0, 4'd0,  0, "leave_in_fg"));
        table_q.push_back(mk(0, 0, 1, 0, 0, 4'd0,  0, "fg_off2"));
        table_q.push_back(mk(1, 0, 8, 1, 1, 4'd1,  0, "mid_request"));

        // Reset held with sensor high.
        reset      = 1'b0;
        sensor_raw = 1'b1;
        fg         = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.detect",  8'(detect),  8'd0);
        chk("reset.present", 8'(present), 8'd0);
        chk("reset.car_cnt", 8'(car_cnt), 8'd0);
        chk("reset.fault",   8'(fault),   8'd0);
        reset = 1'b1;

        foreach (table_q[i]) apply_vec(table_q[i]);

        // Reset in the middle of an active request, released with the
        // sensor still high: full synchronizer + debounce latency again.
        async_reset_check("rst_mid_request");
        apply_vec(mk(1, 0, 5, 0, 0, 4'd0, 0, "rerise_wait"));
        apply_vec(mk(1, 0, 1, 1, 1, 4'd1, 0, "rerise_edge"));

        // Reset in the middle of a rising debounce: nothing must survive.
        apply_vec(mk(0, 0, 8, 1, 0, 4'd1, 0, "drop"));
        apply_vec(mk(1, 0, 4, 1, 0, 4'd1, 0, "mid_debounce"));
        async_reset_check("rst_mid_debounce");
        apply_vec(mk(0, 0, 8, 0, 0, 4'd0, 0, "after_rst_idle"));

`ifdef STUCK_DETECT_EN
        // Sensor stuck high: fault after 64 counted presence cycles, then
        // detect stays forced even while green is on.
        apply_vec(mk(1, 0, 69, 1, 1, 4'd1, 0, "stuck_pre"));
        apply_vec(mk(1, 0, 1,  1, 1, 4'd1, 1, "stuck_fault"));
        apply_vec(mk(1, 1, 2,  1, 1, 4'd0, 1, "stuck_forced"));
        async_reset_check("rst_stuck");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
